// File: rtl/demux_pkg.sv
// Shared types and constants for the demux select sequencer and its command FIFO.
package demux_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int ENTRY_W   = SEL_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/demux_cmd_fifo.sv
// Synchronous command FIFO holding {data, chan} beats; power-of-two depth, no bypass path.
module demux_cmd_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // decide which entries are valid, so the array stays a plain register file.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Buffers (data, channel) beats and replays them onto a 1:N demux with setup,
// hold and dead-time phases so no output line sees in=1 while sel moves.
module demux_sel_sequencer
  import demux_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_data,
  input  logic [SEL_W-1:0]       s_chan,
  output logic                   dmx_in,
  output logic [SEL_W-1:0]       dmx_sel,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = (MAX_PHASE < 2) ? 1 : $clog2(MAX_PHASE + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [SEL_W:0]   head;
  logic             cur_data;

  // Ready is held low during reset so nothing is accepted before release.
  assign s_ready = rst_n && !full;
  assign push    = s_valid && s_ready;
  assign busy    = !empty || (state != IDLE);

  demux_cmd_fifo #(
    .WIDTH (SEL_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({s_data, s_chan}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = DRIVE;
        cnt_n   = HOLD_LOAD;
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (GAP_CYCLES > 0) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
        end else if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // dmx_sel only moves on a pop, which always lands in SETUP where dmx_in is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_data <= 1'b0;
      dmx_sel  <= '0;
      dmx_in   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dmx_in <= (state_n == DRIVE) && cur_data;
      if (pop) begin
        dmx_sel  <= head[SEL_W-1:0];
        cur_data <= head[SEL_W];
      end
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench for demux_sel_sequencer: vector table plus burst, backpressure,
// reset and zero-gap sequences, observed through a behavioural 1:8 demux.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, s_data;
  logic [2:0] s_chan;
  logic       dmx_in;
  logic [2:0] dmx_sel;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] out;

  logic       s_valid2, s_ready2, s_data2;
  logic [2:0] s_chan2;
  logic       dmx_in2;
  logic [2:0] dmx_sel2;
  logic       busy2;
  logic [2:0] fifo_count2;
  logic [7:0] out2;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] outq[$];

  always #5 clk = ~clk;

  demux_sel_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_chan(s_chan), .dmx_in(dmx_in), .dmx_sel(dmx_sel), .busy(busy), .fifo_count(fifo_count)
  );

  demux_sel_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .s_chan(s_chan2), .dmx_in(dmx_in2), .dmx_sel(dmx_sel2), .busy(busy2), .fifo_count(fifo_count2)
  );

  // Behavioural 1:8 combinational demux on each sequencer's outputs.
  always_comb begin
    out = '0;
    out[dmx_sel] = dmx_in;
    out2 = '0;
    out2[dmx_sel2] = dmx_in2;
  end

  typedef struct {
    logic       v;
    logic       d;
    logic [2:0] ch;
    logic       e_in;
    logic [2:0] e_sel;
    logic       e_busy;
    logic [2:0] e_cnt;
    logic [7:0] e_out;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input int n, input int budget, output int acc, output int dlv,
                           output int ready_bad, output int hot_bad, output int full_cyc,
                           output int max_cnt);
    logic prev_in;
    prev_in = 1'b0;
    acc = 0; dlv = 0; ready_bad = 0; hot_bad = 0; full_cyc = 0; max_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      outq.push_back(out);
      if (dmx_in && !prev_in) dlv++;
      prev_in = dmx_in;
      if (s_ready !== (fifo_count != 3'd4)) ready_bad++;
      if ($countones(out) > 1) hot_bad++;
      if (fifo_count == 3'd4 && s_valid) full_cyc++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (acc < n) begin
        s_valid = 1'b1;
        s_data  = 1'b1;
        s_chan  = 3'(acc % 8);
        if (s_ready) acc++;
      end else begin
        s_valid = 1'b0;
      end
      if (acc == n && !s_valid && !busy) break;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int acc, dlv, ready_bad, hot_bad, full_cyc, max_cnt;
    int nruns, bad, j, idx, stray;
    bit seen;

    rst_n = 1'b0;
    s_valid = 0; s_data = 0; s_chan = 0;
    s_valid2 = 0; s_data2 = 0; s_chan2 = 0;

    //             v  d  ch   in sel busy cnt out
    tbl[0]  = '{1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 3'd1, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd0, 8'h20};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd0, 8'h20};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 3'd0, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 3'd3, 1'b0, 3'd5, 1'b1, 3'd1, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 3'd6, 1'b0, 3'd3, 1'b1, 3'd1, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd1, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd1, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd1, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 3'd0, 8'h00};

    // Reset state
    @(negedge clk);
    check("rst.dmx_in",  32'(dmx_in), 32'd0);
    check("rst.dmx_sel", 32'(dmx_sel), 32'd0);
    check("rst.busy",    32'(busy), 32'd0);
    check("rst.s_ready", 32'(s_ready), 32'd0);
    check("rst.count",   32'(fifo_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.s_ready", 32'(s_ready), 32'd1);
    check("rel.busy",    32'(busy), 32'd0);

    // Single beat to chan 5, then data=0 beats to chan 3 and 6
    for (int i = 0; i < 16; i++) begin
      s_valid = tbl[i].v;
      s_data  = tbl[i].d;
      s_chan  = tbl[i].ch;
      @(negedge clk);
      check($sformatf("vec%0d.dmx_in", i),  32'(dmx_in),     32'(tbl[i].e_in));
      check($sformatf("vec%0d.dmx_sel", i), 32'(dmx_sel),    32'(tbl[i].e_sel));
      check($sformatf("vec%0d.busy", i),    32'(busy),       32'(tbl[i].e_busy));
      check($sformatf("vec%0d.count", i),   32'(fifo_count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d.out", i),     32'(out),        32'(tbl[i].e_out));
      check($sformatf("vec%0d.s_ready", i), 32'(s_ready),    32'd1);
    end
    s_valid = 1'b0;

    // Eight back-to-back beats, chan 0..7
    outq.delete();
    run_burst(8, 80, acc, dlv, ready_bad, hot_bad, full_cyc, max_cnt);
    nruns = 0; bad = 0; idx = 0;
    while (idx < outq.size()) begin
      j = idx;
      if (outq[idx] == 8'h00) begin
        while (j < outq.size() && outq[j] == 8'h00) j++;
        if (nruns > 0 && j < outq.size() && (j - idx) != 2) bad++;
      end else begin
        while (j < outq.size() && outq[j] == outq[idx]) j++;
        if (outq[idx] != (8'h01 << nruns) || (j - idx) != 2) bad++;
        nruns++;
      end
      idx = j;
    end
    check("burst8.runs",      32'(nruns), 32'd8);
    check("burst8.shape",     32'(bad), 32'd0);
    check("burst8.onehot",    32'(hot_bad), 32'd0);
    check("burst8.ready",     32'(ready_bad), 32'd0);
    check("burst8.max_count", 32'(max_cnt), 32'd4);
    check("burst8.delivered", 32'(dlv), 32'd8);
    check("burst8.idle",      32'(busy), 32'd0);

    // Backpressure: ten beats with valid held against a full FIFO
    outq.delete();
    run_burst(10, 120, acc, dlv, ready_bad, hot_bad, full_cyc, max_cnt);
    check("bp.accepted",  32'(acc), 32'd10);
    check("bp.delivered", 32'(dlv), 32'(acc));
    check("bp.full_held", 32'(full_cyc >= 2), 32'd1);
    check("bp.ready",     32'(ready_bad), 32'd0);
    check("bp.max_count", 32'(max_cnt), 32'd4);
    check("bp.onehot",    32'(hot_bad), 32'd0);

    // Reset asserted mid-DRIVE
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 1'b1; s_chan = 3'(4 - i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (dmx_in) seen = 1'b1;
      else @(negedge clk);
    end
    check("rstmid.reached_drive", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.dmx_in",  32'(dmx_in), 32'd0);
    check("rstmid.dmx_sel", 32'(dmx_sel), 32'd0);
    check("rstmid.s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid.count",   32'(fifo_count), 32'd0);
    check("rstmid.busy",    32'(busy), 32'd0);
    check("rstmid.s_ready_after", 32'(s_ready), 32'd1);
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dmx_in || dmx_sel != 3'd0 || busy) stray++;
    end
    check("rstmid.no_replay", 32'(stray), 32'd0);

    // HOLD_CYCLES=1, GAP_CYCLES=0: two beats to chan 2
    s_valid2 = 1'b1; s_data2 = 1'b1; s_chan2 = 3'd2;
    @(negedge clk);
    @(negedge clk);
    s_valid2 = 1'b0;
    check("nogap.setup1.sel", 32'(dmx_sel2), 32'd2);
    check("nogap.setup1.out", 32'(out2), 32'h00);
    @(negedge clk);
    check("nogap.drive1.out", 32'(out2), 32'h04);
    @(negedge clk);
    check("nogap.setup2.out", 32'(out2), 32'h00);
    check("nogap.setup2.sel", 32'(dmx_sel2), 32'd2);
    @(negedge clk);
    check("nogap.drive2.out", 32'(out2), 32'h04);
    @(negedge clk);
    check("nogap.idle.out",   32'(out2), 32'h00);
    check("nogap.idle.busy",  32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
